// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ABS = 2'b10;
  localparam logic [1:0] OP_AVG = 2'b11;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - 4-bit combinational ALU: add, subtract, abs-difference, halved sum
module ALU
  import alu_arb_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] op_i,
  output logic [3:0] result_o,
  output logic       zero_o,
  output logic       ovf_o
);

  logic       is_sub;
  logic [3:0] b_x;
  logic [3:0] s;

  // One shared adder; subtract ops feed ~B with carry-in, flags come from the raw sum
  always_comb begin
    is_sub   = (op_i == OP_SUB) || (op_i == OP_ABS);
    b_x      = is_sub ? ~b_i : b_i;
    s        = a_i + b_x + {3'b000, is_sub};
    zero_o   = (s == 4'd0);
    ovf_o    = (a_i[3] == b_x[3]) && (s[3] != a_i[3]);
    result_o = s;
    case (op_i)
      OP_ABS:  result_o = s[3] ? (~s + 4'd1) : s;
      OP_AVG:  result_o = {s[3], s[3:1]};
      default: result_o = s;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_pick2.sv
// rtl/alu_arbiter_rr_pick2.sv - two-way round-robin grant picker
module rr_pick2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  // Under contention the port that did not win last time is chosen
  always_comb begin
    grant_valid_o = |req_valid_i;
    if (&req_valid_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req_valid_i[1] & ~req_valid_i[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one ALU between two ports (option: ALU_ARB_STATS_EN)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_op,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_ovf,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1,
`endif
  output logic       busy
);

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_a_q, op_b_q;
  logic [1:0]       op_sel_q;
  logic [3:0]       rsp_result_q;
  logic             rsp_zero_q, rsp_ovf_q;

  logic             grant, grant_valid;
  logic             accept, rsp_hs, settle_done;
  logic [3:0]       alu_result;
  logic             alu_zero, alu_ovf;

  rr_pick2 u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_valid_o(grant_valid)
  );

  ALU u_alu (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .op_i    (op_sel_q),
    .result_o(alu_result),
    .zero_o  (alu_zero),
    .ovf_o   (alu_ovf)
  );

  assign accept      = (state_q == IDLE) && grant_valid;
  assign rsp_hs      = (state_q == RESP) && rsp_ready[owner_q];
  assign settle_done = (state_q == WAIT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = WAIT;
      WAIT:    if (settle_done) state_d = RESP;
      RESP:    if (rsp_hs)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    req_ready = accept ? (2'b01 << grant) : 2'b00;
    rsp_valid = (state_q == RESP) ? (2'b01 << owner_q) : 2'b00;
    busy      = (state_q != IDLE);
  end

  // Operand latch, settle counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q       <= grant ? req_a[7:4]  : req_a[3:0];
        op_b_q       <= grant ? req_b[7:4]  : req_b[3:0];
        op_sel_q     <= grant ? req_op[3:2] : req_op[1:0];
        owner_q      <= grant;
        last_grant_q <= grant;
        cnt_q        <= CNT_W'(SETTLE_CYCLES - 1);
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (settle_done) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_ovf_q    <= alu_ovf;
      end
    end
  end

  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] gcnt0_q, gcnt1_q;

  // Saturating per-port handshake counters
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else if (accept) begin
      if (!grant && (gcnt0_q != 8'hFF)) gcnt0_q <= gcnt0_q + 8'd1;
      if (grant  && (gcnt1_q != 8'hFF)) gcnt1_q <= gcnt1_q + 8'd1;
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op, rsp_result;
  logic       rsp_zero, rsp_ovf, busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  alu_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // requester / model state
  logic [1:0] pend_v;
  int         pend_a[2], pend_b[2], pend_op[2];
  bit         in_flight;
  int         owner, acc, cyc, ndone, m_last;
  int         gcnt[2];
  logic [5:0] exp_out;
  int         gen_mode, rr_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU from signed arithmetic: returns {ovf, zero, result}
  function automatic logic [5:0] ref_alu(input int a, input int b, input int op);
    int sa, sb, t, s, ss, r;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    t  = (op == 0 || op == 3) ? sa + sb : sa - sb;
    s  = t & 15;
    ss = (s > 7) ? s - 16 : s;
    case (op)
      2:       r = ((ss < 0) ? -ss : ss) & 15;
      3:       r = ((ss < 0) ? (ss - 1) / 2 : ss / 2) & 15;
      default: r = s;
    endcase
    return {(t > 7 || t < -8), (s == 0), 4'(r)};
  endfunction

  task automatic new_req(input int p);
    pend_v[p]  = 1'b1;
    pend_a[p]  = int'($urandom_range(0, 15));
    pend_b[p]  = int'($urandom_range(0, 15));
    pend_op[p] = int'($urandom_range(0, 3));
  endtask

  task automatic do_cycle();
    logic [1:0] exp_rv, exp_rdy;
    int g;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!pend_v[p]) begin
        if (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 2) == 0)) new_req(p);
        else begin
          pend_a[p]  = int'($urandom_range(0, 15));
          pend_b[p]  = int'($urandom_range(0, 15));
          pend_op[p] = int'($urandom_range(0, 3));
        end
      end
    end
    req_valid = pend_v;
    req_a     = {4'(pend_a[1]), 4'(pend_a[0])};
    req_b     = {4'(pend_b[1]), 4'(pend_b[0])};
    req_op    = {2'(pend_op[1]), 2'(pend_op[0])};
    rsp_ready = (rr_mode == 0) ? 2'($urandom_range(0, 3)) : (rr_mode == 1) ? 2'b11 : 2'b00;
    #1;
    chk("busy", busy, in_flight);
    exp_rv = (in_flight && cyc >= acc + S + 1) ? 2'(1 << owner) : 2'b00;
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != 2'b00) begin
      chk("rsp_result", rsp_result, exp_out[3:0]);
      chk("rsp_zero", rsp_zero, exp_out[4]);
      chk("rsp_ovf", rsp_ovf, exp_out[5]);
    end
    g = 0;
    if (pend_v == 2'b11) g = 1 - m_last;
    else if (pend_v == 2'b10) g = 1;
    exp_rdy = (!in_flight && pend_v != 2'b00) ? 2'(1 << g) : 2'b00;
    chk("req_ready", req_ready, exp_rdy);
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, gcnt[0]);
    chk("grant_cnt1", grant_cnt1, gcnt[1]);
`endif
    if (exp_rv != 2'b00 && rsp_ready[owner]) begin
      in_flight = 1'b0;
      ndone++;
    end else if (!in_flight && pend_v != 2'b00) begin
      in_flight = 1'b1;
      owner     = g;
      acc       = cyc;
      m_last    = g;
      exp_out   = ref_alu(pend_a[g], pend_b[g], pend_op[g]);
      if (gcnt[g] < 255) gcnt[g]++;
      pend_v[g] = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_until_done(input int n);
    int start;
    start = ndone;
    for (int i = 0; i < 300 && ndone < start + n; i++) do_cycle();
    chk("done_count", ndone - start, n);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (in_flight || pend_v != 2'b00); i++) do_cycle();
    chk("drained", {in_flight, pend_v}, 3'b000);
  endtask

  task automatic dir(input int p, input int a, input int b, input int op);
    pend_v[p]  = 1'b1;
    pend_a[p]  = a;
    pend_b[p]  = b;
    pend_op[p] = op;
    run_until_done(1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_result", rsp_result, 4'h0);
    chk("rst_rsp_zero", rsp_zero, 1'b0);
    chk("rst_rsp_ovf", rsp_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_grant_cnt0", grant_cnt0, 8'h00);
    chk("rst_grant_cnt1", grant_cnt1, 8'h00);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    pend_v    = 2'b00;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    in_flight = 1'b0;
    m_last    = 1;
    gcnt[0]   = 0;
    gcnt[1]   = 0;
    cyc += 2;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
    pend_v = '0; in_flight = 0; owner = 0; acc = 0; cyc = 0; ndone = 0; m_last = 1;
    gcnt[0] = 0; gcnt[1] = 0; exp_out = '0; gen_mode = 0; rr_mode = 1;
    for (int p = 0; p < 2; p++) begin pend_a[p] = 0; pend_b[p] = 0; pend_op[p] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();

    // directed arithmetic corners
    dir(0, 3, 4, 0);
    dir(1, 7, 1, 0);
    dir(1, 5, 5, 1);
    dir(0, 2, 7, 2);
    dir(1, 8, 0, 2);
    dir(0, 6, 2, 3);
    dir(1, 13, 11, 3);
    dir(0, 0, 8, 1);

    // continuous contention: alternating grants
    gen_mode = 2;
    run_until_done(4);
    gen_mode = 0;
    drain();

    // backpressure with a competing request waiting
    dir(0, 9, 9, 0);
    pend_v[0] = 1'b1; pend_a[0] = 4; pend_b[0] = 12; pend_op[0] = 1;
    rr_mode = 2;
    for (int i = 0; i < 20 && !(in_flight && cyc >= acc + S + 1); i++) do_cycle();
    pend_v[1] = 1'b1; pend_a[1] = 1; pend_b[1] = 2; pend_op[1] = 0;
    repeat (5) do_cycle();
    rr_mode = 1;
    drain();

    // reset while a port-1 request is settling
    pend_v[1] = 1'b1; pend_a[1] = 7; pend_b[1] = 7; pend_op[1] = 0;
    for (int i = 0; i < 10 && !in_flight; i++) do_cycle();
    do_cycle();
    chk("in_wait_before_rst", busy, 1'b1);
    do_reset();
    new_req(0);
    new_req(1);
    run_until_done(1);
    drain();

    // randomized traffic with random response backpressure
    gen_mode = 1;
    rr_mode  = 0;
    repeat (3000) do_cycle();
    gen_mode = 0;
    rr_mode  = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
